// File: rtl/counter_pkg.sv
// Shared constants for the 3-bit down counter: count width, segment table
// and the toggle mask that drives the counter's next-state logic.
package counter_pkg;

  localparam int CNT_W = 3;
  localparam int SEG_W = 7;

  // Segment codes are g..a (bit 6 = g) and active-low.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0][SEG_W-1:0] SEG_TABLE = {
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Down-count toggle mask: bit0 always, bit1 when q0=0, bit2 when q1:q0=00.
  function automatic logic [CNT_W-1:0] down_toggle(input logic [CNT_W-1:0] q);
    return {~q[1] & ~q[0], ~q[0], 1'b1};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex-digit to seven-segment decoder (g..a, active-low); digits 8-F are blank.
module seg7_decoder
  import counter_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!digit[3]) seg = SEG_TABLE[digit[2:0]];
  end

endmodule

// File: rtl/down_counter8.sv
// 3-bit down counter with load, wrap borrow pulse and seven-segment output.
// Build option: DOWN_COUNTER8_ONESHOT_EN makes the count stop at 0 instead of wrapping.
module down_counter8
  import counter_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = 3'd0
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] iData,
  output logic [CNT_W-1:0] oQ,
  output logic             oBorrow,
  output logic [SEG_W-1:0] oDisplay
);

  logic at_zero;
  logic cnt_step;
  logic borrow_nxt;

  assign at_zero = (oQ == '0);

`ifdef DOWN_COUNTER8_ONESHOT_EN
  // Parked at zero until a load or reset restarts it; no wrap, so no borrow.
  assign cnt_step   = en & ~load & ~at_zero;
  assign borrow_nxt = 1'b0;
`else
  assign cnt_step   = en & ~load;
  assign borrow_nxt = en & ~load & at_zero;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      oQ      <= RST_VAL;
      oBorrow <= 1'b0;
    end else begin
      if (load)          oQ <= iData;
      else if (cnt_step) oQ <= oQ ^ down_toggle(oQ);
      oBorrow <= borrow_nxt;
    end
  end

  seg7_decoder u_seg (
    .digit ({1'b0, oQ}),
    .seg   (oDisplay)
  );

endmodule
